fp_int_mul_bit_serial: RTL and testbench

Multiplies an FP16 activation by a signed integer weight that arrives one bit per cycle, MSB first. The weight width is programmable from 1 to 4 bits. It sits in front of the FP-INT accumulator. It emits an unnormalized sign/exponent/integer-mantissa product and a one-cycle `start_acc` strobe, which the accumulator uses to align and add.

---
 rtl/fp_int_pkg.sv | 53 +++++
 rtl/fp_int_mul_bit_serial.sv | 122 ++++++++++++
 tb/tb_fp_int_mul_bit_serial.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fp_int_pkg.sv
// Purpose: shared FP16 field widths, product widths and field-slice helpers for the FP-INT path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fp_int_pkg;

    // FP16 layout: 1 sign, EXP_W exponent, FRAC_W fraction bits.
    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;

    // Mantissa with hidden bit, and the bit-serial weight geometry.
    localparam int MAN_W    = FRAC_W + 1;
    localparam int MAX_PREC = 4;
    localparam int PREC_W   = 4;
    localparam int PQ_W     = 3;
    localparam int CNT_W    = 2;

    // |product| <= 8 * 2047 = 16376 fits PROD_W; the signed partial needs one more bit.
    localparam int PROD_W   = 14;
    localparam int P_W      = PROD_W + 1;

    function automatic logic fp16_sign(input logic [FP16_W-1:0] v);
        return v[FP16_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp16_exp(input logic [FP16_W-1:0] v);
        return v[FRAC_W +: EXP_W];
    endfunction

    function automatic logic [FRAC_W-1:0] fp16_frac(input logic [FP16_W-1:0] v);
        return v[FRAC_W-1:0];
    endfunction

    // Integer mantissa: hidden bit is set for every non-zero exponent code,
    // so subnormals use a hidden 0 and Inf/NaN codes still carry a 1.
    function automatic logic [MAN_W-1:0] fp16_mant(input logic [FP16_W-1:0] v);
        return {(fp16_exp(v) != '0), fp16_frac(v)};
    endfunction

    // Weight width 0 is treated as 1, anything wider than MAX_PREC as MAX_PREC.
    function automatic logic [PQ_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
        logic [PQ_W-1:0] r;
        if (p == '0) begin
            r = PQ_W'(1);
        end else if (p > PREC_W'(MAX_PREC)) begin
            r = PQ_W'(MAX_PREC);
        end else begin
            r = p[PQ_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_int_mul_bit_serial.sv
// Purpose: FP16 activation x bit-serial (MSB first, 1..4 bit) two's-complement weight, unnormalized product.
// Latency: result registers and start_acc update on the edge that samples the last weight bit.
// Backpressure: none; valid=0 simply holds state, so a weight may be paused mid-stream.
module fp_int_mul_bit_serial
    import fp_int_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACT_WIDTH-1:0] act,
    input  logic                 w,
    input  logic                 valid,
    input  logic                 set,
    input  logic [PREC_W-1:0]    precision,
    output logic                 sign_out,
    output logic [EXP_W-1:0]     exp_out,
    output logic [PROD_W-1:0]    mantissa_out,
    output logic                 start_acc
);

    // The accumulator width only matters to the integrator; flag an impossible
    // pairing structurally without adding logic.
    if (ACC_WIDTH < PROD_W) begin : g_acc_narrower_than_product
    end

    logic [PQ_W-1:0]          prec_q;
    logic [CNT_W-1:0]         cnt;
    logic signed [P_W-1:0]    p_q;

    // Activation fields captured on bit 0 so later act changes are ignored.
    logic                     s_a;
    logic [EXP_W-1:0]         e_a;
    logic [MAN_W-1:0]         m_q;

    logic                     first;
    logic                     last;
    logic                     step;
    logic                     s_cur;
    logic [EXP_W-1:0]         e_cur;
    logic [MAN_W-1:0]         m_cur;
    logic signed [P_W-1:0]    addend;
    logic signed [P_W-1:0]    p_nxt;
    logic [PROD_W-1:0]        mag_nxt;
    logic                     sign_nxt;

    // Shift-add datapath: bit 0 carries negative weight (-M), later bits add +M after doubling.
    always_comb begin
        first    = (cnt == '0);
        last     = ({1'b0, cnt} == (prec_q - PQ_W'(1)));
        step     = valid && !set;
        s_cur    = first ? fp16_sign(act[FP16_W-1:0]) : s_a;
        e_cur    = first ? fp16_exp(act[FP16_W-1:0])  : e_a;
        m_cur    = first ? fp16_mant(act[FP16_W-1:0]) : m_q;
        addend   = w ? $signed({{(P_W-MAN_W){1'b0}}, m_cur}) : '0;
        p_nxt    = first ? (-addend) : ((p_q <<< 1) + addend);
        // Low PROD_W bits of the two's-complement negation are exact since |P| < 2^PROD_W.
        mag_nxt  = p_nxt[P_W-1] ? (~p_nxt[PROD_W-1:0] + PROD_W'(1)) : p_nxt[PROD_W-1:0];
        // A zero product is reported as +0 regardless of operand signs.
        sign_nxt = (mag_nxt != '0) && (s_cur ^ p_nxt[P_W-1]);
    end

    // Configuration register; only set touches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prec_q <= PQ_W'(MAX_PREC);
        end else if (set) begin
            prec_q <= clamp_prec(precision);
        end
    end

    // Bit counter and signed partial product; set aborts the weight in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            p_q <= '0;
        end else if (set) begin
            cnt <= '0;
            p_q <= '0;
        end else if (valid) begin
            p_q <= p_nxt;
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Capture activation sign/exponent/mantissa with the weight's sign bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_a <= 1'b0;
            e_a <= '0;
            m_q <= '0;
        end else if (step && first) begin
            s_a <= s_cur;
            e_a <= e_cur;
            m_q <= m_cur;
        end
    end

    // Result registers hold until the next completed weight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_out     <= 1'b0;
            exp_out      <= '0;
            mantissa_out <= '0;
        end else if (step && last) begin
            sign_out     <= sign_nxt;
            exp_out      <= e_cur;
            mantissa_out <= mag_nxt;
        end
    end

    // start_acc is a single-cycle strobe following each completed weight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_acc <= 1'b0;
        end else begin
            start_acc <= step && last;
        end
    end

endmodule

// File: tb/tb_fp_int_mul_bit_serial.sv
module tb_fp_int_mul_bit_serial;

    logic        clk;
    logic        rst;
    logic [15:0] act;
    logic        w;
    logic        valid;
    logic        set;
    logic [3:0]  precision;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [13:0] mantissa_out;
    logic        start_acc;

    int checks = 0;
    int errors = 0;

    fp_int_mul_bit_serial #(
        .ACT_WIDTH (16),
        .ACC_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .act          (act),
        .w            (w),
        .valid        (valid),
        .set          (set),
        .precision    (precision),
        .sign_out     (sign_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .start_acc    (start_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, return at the following negedge.
    task automatic step(input logic v, input logic b, input logic s);
        valid = v;
        w     = b;
        set   = s;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        w     = 1'b0;
        set   = 1'b0;
    endtask

    task automatic do_set(input logic [3:0] p);
        precision = p;
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_result(input string tag, input logic s, input logic [4:0] e, input logic [13:0] m);
        check({tag, "_start"}, 16'(start_acc), 16'd1);
        check({tag, "_sign"},  16'(sign_out), 16'(s));
        check({tag, "_exp"},   16'(exp_out), 16'(e));
        check({tag, "_mant"},  16'(mantissa_out), 16'(m));
    endtask

    initial begin
        int          pulses;
        logic [15:0] pulse_mask;

        rst = 1'b0; act = 16'h0; w = 1'b0; valid = 1'b0; set = 1'b0; precision = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_sign",  16'(sign_out), 16'd0);
        check("reset_exp",   16'(exp_out), 16'd0);
        check("reset_mant",  16'(mantissa_out), 16'd0);
        check("reset_start", 16'(start_acc), 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // +5 x 0x1234 (M=0x634): 5*1588 = 7940 = 0x1F04
        do_set(4'd4);
        act = 16'h1234;
        step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
        check("p5_no_early_start", 16'(start_acc), 16'd0);
        step(1, 1, 0);
        check_result("p5", 1'b0, 5'd4, 14'h1F04);
        step(0, 0, 0);
        check("p5_strobe_one_cycle", 16'(start_acc), 16'd0);
        check("p5_hold", 16'(mantissa_out), 16'h1F04);

        // -6: 6*1588 = 9528 = 0x2538, sign flips
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
        check_result("m6", 1'b1, 5'd4, 14'h2538);

        // -8 x 0xF234 (sign 1, exp 28): 8*1588 = 12704 = 0x31A0, act change after bit 0 ignored
        act = 16'hF234;
        step(1, 1, 0);
        act = 16'h1234;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        check_result("m8", 1'b0, 5'd28, 14'h31A0);

        // Zero weight with negative activation reports +0
        act = 16'hF234;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        check_result("zero", 1'b0, 5'd28, 14'h0);

        // +5 with a 3-cycle pause after bit 1
        act = 16'h1234;
        step(1, 0, 0); step(1, 1, 0);
        act = 16'hFFFF;
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        check("pause_no_start", 16'(start_acc), 16'd0);
        step(1, 0, 0);
        check("pause_bit2_no_start", 16'(start_acc), 16'd0);
        step(1, 1, 0);
        check_result("pause", 1'b0, 5'd4, 14'h1F04);

        // 16 continuous valid cycles of +5: pulses after cycles 3,7,11,15
        act = 16'h1234;
        pulses = 0;
        pulse_mask = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 2) == 1, 1'b0);
            if (start_acc) begin
                pulses++;
                pulse_mask[i] = 1'b1;
            end
        end
        check("stream_pulses", 16'(pulses), 16'd4);
        check("stream_mask", pulse_mask, 16'h8888);
        check("stream_mant", 16'(mantissa_out), 16'h1F04);

        // Asynchronous reset after 2 bits clears outputs immediately
        step(1, 0, 0); step(1, 1, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_sign", 16'(sign_out), 16'd0);
        check("arst_exp",  16'(exp_out), 16'd0);
        check("arst_mant", 16'(mantissa_out), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0);
        check("arst_no_pulse_a", 16'(start_acc), 16'd0);
        step(1, 1, 0);
        check("arst_no_pulse_b", 16'(start_acc), 16'd0);

        // Precision 9 clamps to 4; set also discards the 2 bits above
        do_set(4'd9);
        step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
        check("prec9_no_start_at_3", 16'(start_acc), 16'd0);
        step(1, 1, 0);
        check_result("prec9", 1'b0, 5'd4, 14'h1F04);

        // set on the last-bit cycle aborts that result
        precision = 4'd4;
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(1, 0, 1);
        check("abort_no_start", 16'(start_acc), 16'd0);
        check("abort_hold", 16'(mantissa_out), 16'h1F04);

        // Precision 1, w=1: product is -M, sign inverted
        do_set(4'd1);
        act = 16'h1234;
        step(1, 1, 0);
        check_result("p1_pos", 1'b1, 5'd4, 14'h0634);
        act = 16'hF234;
        step(1, 1, 0);
        check_result("p1_neg", 1'b0, 5'd28, 14'h0634);

        // Precision 0 behaves as 1; subnormal 0x0001 has M=1
        do_set(4'd0);
        act = 16'h0001;
        step(1, 1, 0);
        check_result("p0_subn", 1'b1, 5'd0, 14'h0001);

        // Inf exponent passes through with the integer product (-1 x 0x400)
        act = 16'h7C00;
        step(1, 1, 0);
        check_result("inf", 1'b1, 5'd31, 14'h0400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
